// File: rtl/string_fetch_pkg.sv
// Shared definitions for the string fetch unit: FSM states, little-endian
// byte-lane codes and the string terminator.
package string_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      EMIT,
      FINISH
   } state_t;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

   localparam logic [7:0] NUL = 8'h00;

   function automatic logic isWordBoundary(input logic [1:0] offset);
      return offset == LANE0;
   endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Little-endian byte picker: offset 0 returns bits [7:0], offset 3 bits [31:24].
module byte_lane_select
   import string_fetch_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   output logic [7:0]  laneByte
);

   always_comb begin
      laneByte = word[7:0];
      case (offset)
         LANE0:   laneByte = word[7:0];
         LANE1:   laneByte = word[15:8];
         LANE2:   laneByte = word[23:16];
         LANE3:   laneByte = word[31:24];
         default: laneByte = word[7:0];
      endcase
   end

endmodule

// File: rtl/string_fetch_unit.sv
// Walks a NUL-terminated string in word-addressed memory and streams its bytes
// over a valid/ready port. Define STR_WORD_BUFFER_EN to reuse each fetched word.
module string_fetch_unit
   import string_fetch_pkg::*;
#(
   parameter int unsigned MAX_LEN = 1024,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] str_addr,
   output logic              busy,
   output logic              done,
   output logic              truncated,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rd_data,
   output logic              char_valid,
   output logic [7:0]        char_data,
   input  logic              char_ready
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] nextPtr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  nextCount;
   logic [31:0]       wordReg;
   logic [31:0]       selWord;
   logic [1:0]        selOff;
   logic [7:0]        selByte;
   logic              lastChar;

   // One lane picker serves both the fresh read (in WAIT) and the held word
   // (next byte after a handshake), so char_valid/char_data can be registered.
   always_comb begin
      nextPtr   = ptr + ADDR_W'(1);
      nextCount = count + CNT_W'(1);
      lastChar  = (nextCount == CNT_W'(MAX_LEN));
      selWord   = wordReg;
      selOff    = nextPtr[1:0];
      if (state == WAIT) begin
         selWord = mem_rd_data;
         selOff  = ptr[1:0];
      end
   end

   byte_lane_select laneSel (
      .word     (selWord),
      .offset   (selOff),
      .laneByte (selByte)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         truncated  <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         char_valid <= 1'b0;
         char_data  <= '0;
         ptr        <= '0;
         count      <= '0;
         wordReg    <= '0;
      end else begin
         done      <= 1'b0;
         truncated <= 1'b0;
         mem_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ptr       <= str_addr;
                  count     <= '0;
                  busy      <= 1'b1;
                  mem_rd_en <= 1'b1;
                  mem_addr  <= {str_addr[ADDR_W-1:2], 2'b00};
                  state     <= FETCH;
               end
            end

            FETCH: state <= WAIT;

            WAIT: begin
               wordReg    <= mem_rd_data;
               char_data  <= selByte;
               char_valid <= (selByte != NUL);
               state      <= EMIT;
            end

            EMIT: begin
               // char_valid low in EMIT means the selected byte was the terminator
               if (!char_valid) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (char_ready) begin
                  ptr        <= nextPtr;
                  count      <= nextCount;
                  char_valid <= 1'b0;
                  if (lastChar) begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     truncated <= 1'b1;
                     state     <= FINISH;
                  end
`ifdef STR_WORD_BUFFER_EN
                  else if (!isWordBoundary(nextPtr[1:0])) begin
                     char_data  <= selByte;
                     char_valid <= (selByte != NUL);
                  end
`endif
                  else begin
                     mem_rd_en <= 1'b1;
                     mem_addr  <= {nextPtr[ADDR_W-1:2], 2'b00};
                     state     <= FETCH;
                  end
               end
            end

            FINISH: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_string_fetch_unit.sv
// Directed bench for string_fetch_unit; expected read counts follow STR_WORD_BUFFER_EN.
module tb_string_fetch_unit;

`ifdef STR_WORD_BUFFER_EN
   localparam int S1_READS = 1;
   localparam int S2_READS = 2;
   localparam int S4_READS = 1;
`else
   localparam int S1_READS = 4;
   localparam int S2_READS = 4;
   localparam int S4_READS = 4;
`endif

   logic        clk;
   logic        rst_n;
   logic        charReady;
   logic [31:0] strAddr;

   logic        startL, busyL, doneL, truncL, rdEnL, cvL;
   logic [31:0] addrL, rdDataL;
   logic [7:0]  cdL;
   logic        startS, busyS, doneS, truncS, rdEnS, cvS;
   logic [31:0] addrS, rdDataS;
   logic [7:0]  cdS;

   logic [31:0] mem [logic [31:0]];
   logic [7:0]  charQL [$];
   logic [7:0]  charQS [$];
   logic [31:0] rdAddrQ [$];
   int          rdCountL = 0;
   int          rdCountS = 0;

   int checks   = 0;
   int failures = 0;

   string_fetch_unit #(.MAX_LEN(1024), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(startL), .str_addr(strAddr),
      .busy(busyL), .done(doneL), .truncated(truncL),
      .mem_rd_en(rdEnL), .mem_addr(addrL), .mem_rd_data(rdDataL),
      .char_valid(cvL), .char_data(cdL), .char_ready(charReady)
   );

   string_fetch_unit #(.MAX_LEN(4), .ADDR_W(32)) dutShort (
      .clk(clk), .rst_n(rst_n), .start(startS), .str_addr(strAddr),
      .busy(busyS), .done(doneS), .truncated(truncS),
      .mem_rd_en(rdEnS), .mem_addr(addrS), .mem_rd_data(rdDataS),
      .char_valid(cvS), .char_data(cdS), .char_ready(charReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Memory answers one cycle after the strobe; handshakes and reads are logged.
   always @(posedge clk) begin
      if (rdEnL) begin
         rdCountL++;
         rdAddrQ.push_back(addrL);
         rdDataL <= memRead(addrL);
      end
      if (rdEnS) begin
         rdCountS++;
         rdDataS <= memRead(addrS);
      end
      if (cvL && charReady) charQL.push_back(cdL);
      if (cvS && charReady) charQS.push_back(cdS);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // expChars holds the expected characters, first character in the low byte.
   task automatic checkChars(input string tag, input logic [7:0] q[$], input int base,
                             input logic [31:0] expChars, input int n);
      logic [31:0] got;
      checkVal({tag, "_count"}, 32'(q.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         got = (base + i < q.size()) ? 32'(q[base + i]) : 32'hFFFF_FFFF;
         checkVal($sformatf("%s_char%0d", tag, i), got, 32'(expChars[8*i +: 8]));
      end
   endtask

   task automatic pulseStart(input bit shortDut, input logic [31:0] addr);
      strAddr = addr;
      if (shortDut) startS = 1'b1;
      else          startL = 1'b1;
      @(negedge clk);
      startL = 1'b0;
      startS = 1'b0;
   endtask

   task automatic waitDone(input bit shortDut, input string tag);
      int n;
      n = 0;
      while (!(shortDut ? doneS : doneL) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) checkVal({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic waitCharL(input logic [7:0] c);
      int n;
      n = 0;
      while (!(cvL && cdL == c) && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int base, rdBase, rdSnap, cyc, stable;
      bit cvSeen;

      rst_n = 1'b0; startL = 1'b0; startS = 1'b0; charReady = 1'b0; strAddr = '0;
      repeat (3) @(negedge clk);
      checkVal("reset_ctrl", 32'({busyL, doneL, truncL, rdEnL, cvL}), 32'd0);
      checkVal("reset_char_data", 32'(cdL), 32'd0);
      checkVal("reset_mem_addr", addrL, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // "Hi!\0" in one word, consumer always ready
      mem[32'h10010000] = 32'h0021_6948;
      charReady = 1'b1;
      base = charQL.size(); rdBase = rdAddrQ.size(); rdSnap = rdCountL;
      pulseStart(1'b0, 32'h10010000);
      cyc = 1;
      while (!cvL && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkVal("s1_first_char_cycle", 32'(cyc), 32'd3);
      waitDone(1'b0, "s1");
      checkVal("s1_truncated", 32'(truncL), 32'd0);
      checkChars("s1", charQL, base, 32'h0021_6948, 3);
      checkVal("s1_reads", 32'(rdCountL - rdSnap), 32'(S1_READS));
      checkVal("s1_addr0", rdAddrQ[rdBase], 32'h10010000);
      @(negedge clk);

      // unaligned start straddling two words
      mem[32'h10010000] = 32'h4100_0000;
      mem[32'h10010004] = 32'h0000_4342;
      base = charQL.size(); rdBase = rdAddrQ.size(); rdSnap = rdCountL;
      pulseStart(1'b0, 32'h10010003);
      waitDone(1'b0, "s2");
      checkChars("s2", charQL, base, 32'h0043_4241, 3);
      checkVal("s2_reads", 32'(rdCountL - rdSnap), 32'(S2_READS));
      checkVal("s2_addr0", rdAddrQ[rdBase], 32'h10010000);
      checkVal("s2_addr1", rdAddrQ[rdBase + 1], 32'h10010004);
      @(negedge clk);

      // back-pressure on the second character; a start during the stall is ignored
      mem[32'h10010020] = 32'h005A_5958;
      charReady = 1'b0;
      base = charQL.size();
      pulseStart(1'b0, 32'h10010020);
      waitCharL(8'h58);
      charReady = 1'b1;
      @(negedge clk);
      charReady = 1'b0;
      waitCharL(8'h59);
      rdSnap = rdCountL;
      stable = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (cvL && cdL == 8'h59) stable++;
         if (i == 2) begin
            strAddr = 32'h10010080;
            startL  = 1'b1;
         end
         if (i == 3) startL = 1'b0;
      end
      checkVal("s3_stall_reads", 32'(rdCountL - rdSnap), 32'd0);
      checkVal("s3_stable_cycles", 32'(stable), 32'd6);
      charReady = 1'b1;
      waitDone(1'b0, "s3");
      checkChars("s3", charQL, base, 32'h005A_5958, 3);
      @(negedge clk);

      // MAX_LEN=4 instance cuts "ABCDEFG" after four characters
      mem[32'h10020000] = 32'h4443_4241;
      mem[32'h10020004] = 32'h0047_4645;
      base = charQS.size(); rdSnap = rdCountS;
      pulseStart(1'b1, 32'h10020000);
      waitDone(1'b1, "s4");
      checkVal("s4_truncated", 32'(truncS), 32'd1);
      checkChars("s4", charQS, base, 32'h4443_4241, 4);
      checkVal("s4_reads", 32'(rdCountS - rdSnap), 32'(S4_READS));
      @(negedge clk);

      // reset while the second character waits, start held during reset
      mem[32'h10010040] = 32'h0033_3231;
      charReady = 1'b0;
      pulseStart(1'b0, 32'h10010040);
      waitCharL(8'h31);
      charReady = 1'b1;
      @(negedge clk);
      charReady = 1'b0;
      waitCharL(8'h32);
      rst_n  = 1'b0;
      startL = 1'b1;
      @(negedge clk);
      checkVal("s5_reset_ctrl", 32'({busyL, doneL, truncL, rdEnL, cvL}), 32'd0);
      checkVal("s5_reset_char_data", 32'(cdL), 32'd0);
      checkVal("s5_reset_mem_addr", addrL, 32'd0);
      rst_n  = 1'b1;
      startL = 1'b0;
      @(negedge clk);
      checkVal("s5_start_ignored_in_reset", 32'(busyL), 32'd0);
      charReady = 1'b1;
      base = charQL.size();
      pulseStart(1'b0, 32'h10010040);
      waitDone(1'b0, "s5");
      checkVal("s5_truncated", 32'(truncL), 32'd0);
      checkChars("s5", charQL, base, 32'h0033_3231, 3);
      @(negedge clk);

      // empty string: done three edges after the accepting edge, no character
      mem[32'h10010080] = 32'h4142_4300;
      rdSnap = rdCountL;
      pulseStart(1'b0, 32'h10010080);
      cyc = 0;
      cvSeen = 1'b0;
      while (!doneL && cyc < 20) begin
         cvSeen = cvSeen | cvL;
         @(negedge clk);
         cyc++;
      end
      checkVal("s6_done_latency", 32'(cyc), 32'd3);
      checkVal("s6_no_char_valid", 32'(cvSeen), 32'd0);
      checkVal("s6_busy_at_done", 32'(busyL), 32'd0);
      checkVal("s6_truncated", 32'(truncL), 32'd0);
      checkVal("s6_reads", 32'(rdCountL - rdSnap), 32'd1);
      @(negedge clk);
      checkVal("s6_done_one_cycle", 32'(doneL), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
